// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolver: funct3 codes, FSM states, flush counter width.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational funct3 condition evaluation; funct3 010/011 flag illegal and force cond low.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond,
    output logic            illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (a == b);
            F3_BNE:  cond = (a != b);
            F3_BLT:  cond = ($signed(a) <  $signed(b));
            F3_BGE:  cond = ($signed(a) >= $signed(b));
            F3_BLTU: cond = (a <  b);
            F3_BGEU: cond = (a >= b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Sequential branch resolver: accept in IDLE, registered response one cycle later, FLUSH_CYCLES flush on taken.
// ReqReady is low outside IDLE; optional statistics counters under BRANCH_STATS_EN.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Rs1Data,
    input  logic [XLEN-1:0] Rs2Data,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Imm,
    output logic            RespValid,
    output logic            Taken,
    output logic [XLEN-1:0] Target,
    output logic            Illegal,
    output logic            Misaligned,
    output logic            Flush,
    output logic [31:0]     TakenCount,
    output logic [31:0]     BranchCount
);

    state_t                 state, state_nxt;
    logic [2:0]             f3_q;
    logic [XLEN-1:0]        rs1_q, rs2_q, pc_q, imm_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt;

    logic                   cond, illegal_c, misal_c, taken_c;
    logic [XLEN-1:0]        target_c;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .funct3  (f3_q),
        .a       (rs1_q),
        .b       (rs2_q),
        .cond    (cond),
        .illegal (illegal_c)
    );

    assign target_c = pc_q + imm_q;
    assign misal_c  = cond & (target_c[1:0] != 2'b00);
    assign taken_c  = cond & ~misal_c;

    assign ReqReady = (state == ST_IDLE);
    assign Flush    = (state == ST_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ReqValid) state_nxt = ST_EVAL;
            ST_EVAL:  state_nxt = taken_c ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (flush_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured only at accept so later input changes cannot leak into the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q  <= 3'b000;
            rs1_q <= '0;
            rs2_q <= '0;
            pc_q  <= '0;
            imm_q <= '0;
        end else if (state == ST_IDLE && ReqValid) begin
            f3_q  <= funct3;
            rs1_q <= Rs1Data;
            rs2_q <= Rs2Data;
            pc_q  <= PC;
            imm_q <= Imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RespValid  <= 1'b0;
            Taken      <= 1'b0;
            Target     <= '0;
            Illegal    <= 1'b0;
            Misaligned <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            RespValid <= (state == ST_EVAL);
            if (state == ST_EVAL) begin
                Taken      <= taken_c;
                Target     <= target_c;
                Illegal    <= illegal_c;
                Misaligned <= misal_c;
                flush_cnt  <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            end else if (state == ST_FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt, taken_cnt;

    // Counted on the edge that launches the response, so counts line up with RespValid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (state == ST_EVAL) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (taken_c) taken_cnt <= taken_cnt + 32'd1;
        end
    end

    assign BranchCount = branch_cnt;
    assign TakenCount  = taken_cnt;
`else
    assign BranchCount = 32'd0;
    assign TakenCount  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (FLUSH_CYCLES=2).
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  funct3;
    logic [31:0] Rs1Data, Rs2Data, PC, Imm;
    logic        RespValid, Taken, Illegal, Misaligned, Flush;
    logic [31:0] Target, TakenCount, BranchCount;

    int checks = 0;
    int errors = 0;

    branch_resolver #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .funct3      (funct3),
        .Rs1Data     (Rs1Data),
        .Rs2Data     (Rs2Data),
        .PC          (PC),
        .Imm         (Imm),
        .RespValid   (RespValid),
        .Taken       (Taken),
        .Target      (Target),
        .Illegal     (Illegal),
        .Misaligned  (Misaligned),
        .Flush       (Flush),
        .TakenCount  (TakenCount),
        .BranchCount (BranchCount)
    );

    always #5 clk = ~clk;

    // Called at a negedge with ReqReady high; accept happens on the next posedge.
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
        funct3 = f; Rs1Data = a; Rs2Data = b; PC = p; Imm = i;
        ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        funct3 = 3'b000; Rs1Data = 32'hDEAD_0001; Rs2Data = 32'hDEAD_0002;
        PC = 32'h0; Imm = 32'h3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ReqReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle timeout: ReqReady=%b required 1", ReqReady);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ReqValid = 1'b0; funct3 = 3'b000;
        Rs1Data = '0; Rs2Data = '0; PC = '0; Imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ReqReady, RespValid, Taken, Illegal, Misaligned, Flush} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 100000",
                     {ReqReady, RespValid, Taken, Illegal, Misaligned, Flush});
        end
        checks++;
        if (Target !== 32'h0 || BranchCount !== 32'h0 || TakenCount !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: Target=%h Branch=%0d Taken=%0d required 0",
                     Target, BranchCount, TakenCount);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_beq_taken();
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        @(negedge clk);
        checks++;
        if (RespValid !== 1'b0 || ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL beq_eval: RespValid=%b ReqReady=%b required 0 0", RespValid, ReqReady);
        end
        @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Taken !== 1'b1 || Target !== 32'h120 || Flush !== 1'b1 || ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL beq_resp: Rv=%b Tk=%b Tgt=%h Fl=%b Rdy=%b required 1 1 00000120 1 0",
                     RespValid, Taken, Target, Flush, ReqReady);
        end
        @(negedge clk);
        checks++;
        if (RespValid !== 1'b0 || Flush !== 1'b1 || ReqReady !== 1'b0 || Taken !== 1'b1) begin
            errors++;
            $display("FAIL beq_flush2: Rv=%b Fl=%b Rdy=%b Tk=%b required 0 1 0 1",
                     RespValid, Flush, ReqReady, Taken);
        end
        @(negedge clk);
        checks++;
        if (Flush !== 1'b0 || ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL beq_release: Fl=%b Rdy=%b required 0 1", Flush, ReqReady);
        end
    endtask

    task automatic test_blt_bltu();
        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8);
        repeat (2) @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Taken !== 1'b1 || Target !== 32'h208 || Flush !== 1'b1) begin
            errors++;
            $display("FAIL blt_signed: Rv=%b Tk=%b Tgt=%h Fl=%b required 1 1 00000208 1",
                     RespValid, Taken, Target, Flush);
        end
        wait_idle();
        send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8);
        repeat (2) @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Taken !== 1'b0 || Flush !== 1'b0 || ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL bltu_unsigned: Rv=%b Tk=%b Fl=%b Rdy=%b required 1 0 0 1",
                     RespValid, Taken, Flush, ReqReady);
        end
        send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Taken !== 1'b1 || Target !== 32'h2FC || Flush !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_bgeu: Rv=%b Tk=%b Tgt=%h Fl=%b required 1 1 000002fc 1",
                     RespValid, Taken, Target, Flush);
        end
        wait_idle();
    endtask

    task automatic test_illegal();
        logic fl_seen = 1'b0;
        send(3'b010, 32'd7, 32'd7, 32'h400, 32'h10);
        @(negedge clk);
        fl_seen = Flush;
        @(negedge clk);
        fl_seen = fl_seen | Flush;
        checks++;
        if (RespValid !== 1'b1 || Illegal !== 1'b1 || Taken !== 1'b0 || Target !== 32'h410 || Misaligned !== 1'b0) begin
            errors++;
            $display("FAIL illegal_resp: Rv=%b Il=%b Tk=%b Tgt=%h Mis=%b required 1 1 0 00000410 0",
                     RespValid, Illegal, Taken, Target, Misaligned);
        end
        @(negedge clk);
        fl_seen = fl_seen | Flush;
        checks++;
        if (fl_seen !== 1'b0 || ReqReady !== 1'b1 || RespValid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_noflush: flush_seen=%b Rdy=%b Rv=%b required 0 1 0",
                     fl_seen, ReqReady, RespValid);
        end
    endtask

    task automatic test_misaligned_wrap();
        send(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h12);
        repeat (2) @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Target !== 32'h2 || Misaligned !== 1'b1 || Taken !== 1'b0 ||
            Illegal !== 1'b0 || Flush !== 1'b0 || ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_wrap: Rv=%b Tgt=%h Mis=%b Tk=%b Il=%b Fl=%b Rdy=%b required 1 00000002 1 0 0 0 1",
                     RespValid, Target, Misaligned, Taken, Illegal, Flush, ReqReady);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        send(3'b000, 32'd9, 32'd9, 32'h500, 32'h40);
        repeat (2) @(negedge clk);
        checks++;
        if (Flush !== 1'b1 || Target !== 32'h540) begin
            errors++;
            $display("FAIL pre_reset_flush: Fl=%b Tgt=%h required 1 00000540", Flush, Target);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (Flush !== 1'b0 || ReqReady !== 1'b1 || RespValid !== 1'b0 || Taken !== 1'b0 || Target !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_flush: Fl=%b Rdy=%b Rv=%b Tk=%b Tgt=%h required 0 1 0 0 00000000",
                     Flush, ReqReady, RespValid, Taken, Target);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(3'b101, 32'd3, 32'd3, 32'h600, 32'h8);
        repeat (2) @(negedge clk);
        checks++;
        if (RespValid !== 1'b1 || Taken !== 1'b1 || Target !== 32'h608 || Flush !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_bge: Rv=%b Tk=%b Tgt=%h Fl=%b required 1 1 00000608 1",
                     RespValid, Taken, Target, Flush);
        end
        wait_idle();
    endtask

    task automatic test_stats();
        logic [31:0] exp_b, exp_t;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'b000, 32'd4, 32'd4, 32'h0, 32'h4);            wait_idle(); // taken
        send(3'b001, 32'd1, 32'd1, 32'h0, 32'h4);            wait_idle(); // not taken
        send(3'b110, 32'd1, 32'd2, 32'h0, 32'h4);            wait_idle(); // taken
        send(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h4);    wait_idle(); // not taken
        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h4);    wait_idle(); // taken
`ifdef BRANCH_STATS_EN
        exp_b = 32'd5; exp_t = 32'd3;
`else
        exp_b = 32'd0; exp_t = 32'd0;
`endif
        checks++;
        if (BranchCount !== exp_b || TakenCount !== exp_t) begin
            errors++;
            $display("FAIL stats: Branch=%0d Taken=%0d required %0d %0d",
                     BranchCount, TakenCount, exp_b, exp_t);
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_blt_bltu();
        test_illegal();
        test_misaligned_wrap();
        test_reset_mid_flush();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
